// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  localparam logic [1:0]  QUEUE_DEPTH = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs; entry 0 is always the head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [width-1:0] i_push_pc,
  input  logic [width-1:0] i_push_instr,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [1:0]       o_count,
  output logic             o_head_valid,
  output logic [width-1:0] o_head_pc,
  output logic [width-1:0] o_head_instr
);

  logic [width-1:0] r_pc0;
  logic [width-1:0] r_instr0;
  logic [width-1:0] r_pc1;
  logic [width-1:0] r_instr1;
  logic [1:0]       r_count;

  logic w_doPop;
  logic w_doPush;

  assign w_doPop  = i_pop && (r_count != 2'd0);
  assign w_doPush = i_push && ((r_count != QUEUE_DEPTH) || w_doPop);

  // Flush only clears the occupancy; stale data is invisible once count is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc0    <= '0;
      r_instr0 <= '0;
      r_pc1    <= '0;
      r_instr1 <= '0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_doPush, w_doPop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0    <= i_push_pc;
            r_instr0 <= i_push_instr;
          end else begin
            r_pc1    <= i_push_pc;
            r_instr1 <= i_push_instr;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc0    <= r_pc1;
          r_instr0 <= r_instr1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_pc0    <= i_push_pc;
            r_instr0 <= i_push_instr;
          end else begin
            r_pc0    <= r_pc1;
            r_instr0 <= r_instr1;
            r_pc1    <= i_push_pc;
            r_instr1 <= i_push_instr;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != 2'd0);
  assign o_head_pc    = r_pc0;
  assign o_head_instr = r_instr0;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, redirect handling and the next-PC mux,
// feeding a two-entry queue toward decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] pc,
  output logic [width-1:0] pc_next,
  input  logic             redirect_valid,
  input  logic [width-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [width-1:0] imem_addr,
  input  logic             imem_resp_valid,
  input  logic [width-1:0] imem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_instr,
  output logic [width-1:0] out_pc
);

  fetch_state_e     r_state;
  logic [width-1:0] r_reqPc;

  logic [1:0]       w_count;
  logic             w_reqValid;
  logic             w_handshake;
  logic             w_push;

  assign w_reqValid  = !rst && (r_state == REQ) && (w_count < QUEUE_DEPTH) && !redirect_valid;
  assign w_handshake = w_reqValid && imem_req_ready;
  assign w_push      = (r_state == WAIT) && imem_resp_valid && !redirect_valid;

  always_comb begin
    pc_next = pc;
    if (rst) begin
      pc_next = width'(RESET_PC);
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (w_handshake) begin
      pc_next = pc + width'(INSTR_BYTES);
    end
  end

  // A redirect with a request in flight parks in DRAIN so the stale reply is eaten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_reqPc <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (w_handshake) begin
            r_state <= WAIT;
            r_reqPc <= pc;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            r_state <= REQ;
          end else if (redirect_valid) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) begin
            r_state <= REQ;
          end
        end
        default: begin
          r_state <= REQ;
        end
      endcase
    end
  end

  fetch_queue #(
    .width(width)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_pc    (r_reqPc),
    .i_push_instr (imem_resp_data),
    .i_pop        (out_ready),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_head_valid (out_valid),
    .o_head_pc    (out_pc),
    .o_head_instr (out_instr)
  );

  assign imem_req_valid = w_reqValid;
  assign imem_addr      = pc;

endmodule
